// File: rtl/demux_fix_pkg.sv
// Shared constants, lane-index type and select-range helper for the 1-to-31 symbol demux.
package demux_fix_pkg;

  localparam int NUM_OUT = 31;
  localparam int DATA_W  = 2;
  localparam int SEL_W   = 5;
  localparam int CNT_W   = 8;

  typedef logic [SEL_W-1:0] lane_idx_t;

  // Unsigned range check; a select at or beyond num_out addresses no lane.
  function automatic logic lane_valid(input lane_idx_t sel, input int num_out = NUM_OUT);
    return (int'(sel) < num_out);
  endfunction

endpackage

// File: rtl/demux_fix_lane.sv
// One-entry output buffer for a single demux lane; fill takes priority over drain.
module demux_fix_lane
  import demux_fix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;

  // A fill in the same cycle as a drain keeps the buffer occupied with the new symbol.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (fill) begin
      valid_reg <= 1'b1;
      data_reg  <= fill_data;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/demux_fix_seq.sv
// Registered 1-to-31 demultiplexer of 2-bit symbols with per-lane valid/ready drains
// and a saturating counter for transfers whose select addresses no lane.
module demux_fix_seq
  import demux_fix_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [DATA_W-1:0]         in_data,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic                      err_sticky,
  output logic [CNT_W-1:0]          drop_count,
  input  logic                      err_clr
);

  logic               sel_ok;
  logic               accept;
  logic               drop;
  logic [NUM_OUT-1:0] fill;

  logic             err_sticky_reg;
  logic             err_sticky_next;
  logic [CNT_W-1:0] drop_count_reg;
  logic [CNT_W-1:0] drop_count_next;

  assign sel_ok = lane_valid(in_sel, NUM_OUT);

  // Readiness only looks at the addressed lane, never at in_valid.
  always_comb begin
    in_ready = 1'b1;
    if (sel_ok) begin
      in_ready = !out_valid[in_sel] || out_ready[in_sel];
    end
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !sel_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_lane
      assign fill[gi] = accept && sel_ok && (in_sel == SEL_W'(gi));

      demux_fix_lane u_lane (
        .clk       (clk),
        .reset     (reset),
        .fill      (fill[gi]),
        .fill_data (in_data),
        .out_ready (out_ready[gi]),
        .out_valid (out_valid[gi]),
        .out_data  (out_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // A clear wipes the old state but still records a drop arriving on the same edge.
  always_comb begin
    err_sticky_next = err_sticky_reg;
    drop_count_next = drop_count_reg;
    if (err_clr) begin
      err_sticky_next = drop;
      drop_count_next = drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      err_sticky_next = 1'b1;
      if (drop_count_reg != {CNT_W{1'b1}}) begin
        drop_count_next = drop_count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky_reg <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      err_sticky_reg <= err_sticky_next;
      drop_count_reg <= drop_count_next;
    end
  end

  assign err_sticky = err_sticky_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_demux_fix_seq.sv
// Self-checking bench for demux_fix_seq: expected lane symbols are queued when driven
// and popped when the lane register is sampled one cycle later.
module tb_demux_fix_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_sel;
  logic [1:0]  in_data;
  logic [61:0] out_data;
  logic [30:0] out_valid;
  logic [30:0] out_ready;
  logic        err_sticky;
  logic [7:0]  drop_count;
  logic        err_clr;

  typedef struct {
    int         lane;
    logic [1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  demux_fix_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_sticky (err_sticky),
    .drop_count (drop_count),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_sel    = 5'd0;
    in_data   = 2'b00;
    out_ready = '0;
    err_clr   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic send(input int sel, input logic [1:0] d);
    in_valid = 1'b1;
    in_sel   = 5'(sel);
    in_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 31'h0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %h expected %h", out_valid, 31'h0);
    end
    n_checks++;
    if (out_data !== 62'h0) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h expected %h", out_data, 62'h0);
    end
    n_checks++;
    if (err_sticky !== 1'b0 || drop_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_err: got err=%b cnt=%h expected err=0 cnt=00", err_sticky, drop_count);
    end
    $display("txn reset: out_valid=%h drop_count=%h", out_valid, drop_count);
  endtask

  task automatic test_single_fill();
    exp_t        e;
    logic [61:0] exp_vec;
    send(5, 2'b10);
    sb_q.push_back('{lane: 5, data: 2'b10});
    step();
    in_valid = 1'b0;
    e = sb_q.pop_front();
    exp_vec = '0;
    exp_vec[e.lane*2 +: 2] = e.data;
    n_checks++;
    if (out_valid !== 31'h0000_0020) begin
      n_fail++;
      $display("FAIL single_fill_valid: got %h expected %h", out_valid, 31'h0000_0020);
    end
    n_checks++;
    if (out_data !== exp_vec) begin
      n_fail++;
      $display("FAIL single_fill_data: got %h expected %h", out_data, exp_vec);
    end
    $display("txn single_fill: lane=%0d data=%b out_valid=%h", e.lane, out_data[11:10], out_valid);
  endtask

  task automatic test_backpressure();
    exp_t e;
    send(5, 2'b01);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ready: got %b expected 0", in_ready);
    end
    step();
    n_checks++;
    if (out_data[11:10] !== 2'b10 || out_valid[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: got v=%b d=%b expected v=1 d=10", out_valid[5], out_data[11:10]);
    end
    out_ready[5] = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL passthru_ready: got %b expected 1", in_ready);
    end
    sb_q.push_back('{lane: 5, data: 2'b01});
    step();
    in_valid  = 1'b0;
    out_ready = '0;
    e = sb_q.pop_front();
    n_checks++;
    if (out_valid[e.lane] !== 1'b1 || out_data[e.lane*2 +: 2] !== e.data) begin
      n_fail++;
      $display("FAIL passthru_data: got v=%b d=%b expected v=1 d=%b",
               out_valid[e.lane], out_data[e.lane*2 +: 2], e.data);
    end
    $display("txn backpressure: lane=5 data=%b", out_data[11:10]);
  endtask

  task automatic test_fill_all();
    exp_t e;
    do_reset();
    for (int i = 0; i < 31; i++) begin
      send(i, 2'(i));
      sb_q.push_back('{lane: i, data: 2'(i)});
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 31'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL fill_all_valid: got %h expected %h", out_valid, 31'h7FFF_FFFF);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (out_data[e.lane*2 +: 2] !== e.data) begin
        n_fail++;
        $display("FAIL fill_all_lane%0d: got %b expected %b", e.lane, out_data[e.lane*2 +: 2], e.data);
      end
    end
    $display("txn fill_all: out_valid=%h lane12=%b lane13=%b", out_valid, out_data[25:24], out_data[27:26]);
  endtask

  task automatic test_drops();
    int bad_ready = 0;
    for (int i = 0; i < 260; i++) begin
      send(31, 2'b11);
      #1;
      if (in_ready !== 1'b1) bad_ready++;
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad_ready != 0) begin
      n_fail++;
      $display("FAIL drop_ready: in_ready low on %0d cycles expected 0", bad_ready);
    end
    n_checks++;
    if (err_sticky !== 1'b1 || drop_count !== 8'hFF) begin
      n_fail++;
      $display("FAIL drop_saturate: got err=%b cnt=%h expected err=1 cnt=ff", err_sticky, drop_count);
    end
    n_checks++;
    if (out_valid !== 31'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL drop_lanes: got %h expected %h", out_valid, 31'h7FFF_FFFF);
    end
    send(31, 2'b00);
    err_clr = 1'b1;
    step();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    n_checks++;
    if (err_sticky !== 1'b1 || drop_count !== 8'h01) begin
      n_fail++;
      $display("FAIL clr_with_drop: got err=%b cnt=%h expected err=1 cnt=01", err_sticky, drop_count);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (err_sticky !== 1'b0 || drop_count !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_only: got err=%b cnt=%h expected err=0 cnt=00", err_sticky, drop_count);
    end
    $display("txn drops: err_sticky=%b drop_count=%h", err_sticky, drop_count);
  endtask

  task automatic test_concurrent();
    exp_t e;
    do_reset();
    send(3, 2'b01);
    step();
    send(7, 2'b10);
    step();
    out_ready = (31'b1 << 3) | (31'b1 << 7);
    send(7, 2'b11);
    sb_q.push_back('{lane: 7, data: 2'b11});
    step();
    in_valid  = 1'b0;
    out_ready = '0;
    e = sb_q.pop_front();
    n_checks++;
    if (out_valid !== (31'b1 << 7)) begin
      n_fail++;
      $display("FAIL concurrent_valid: got %h expected %h", out_valid, 31'b1 << 7);
    end
    n_checks++;
    if (out_data[e.lane*2 +: 2] !== e.data || out_data[7:6] !== 2'b01) begin
      n_fail++;
      $display("FAIL concurrent_data: got l7=%b l3=%b expected l7=%b l3=01",
               out_data[15:14], out_data[7:6], e.data);
    end
    $display("txn concurrent: out_valid=%h lane7=%b", out_valid, out_data[15:14]);
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [1:0] d;
    out_ready[9] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 2'($urandom_range(0, 3));
      send(9, d);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready_%0d: got %b expected 1", i, in_ready);
      end
      sb_q.push_back('{lane: 9, data: d});
      step();
      e = sb_q.pop_front();
      n_checks++;
      if (out_valid[e.lane] !== 1'b1 || out_data[e.lane*2 +: 2] !== e.data) begin
        n_fail++;
        $display("FAIL b2b_data_%0d: got v=%b d=%b expected v=1 d=%b",
                 i, out_valid[e.lane], out_data[e.lane*2 +: 2], e.data);
      end
      $display("txn b2b: lane=9 data=%b", out_data[19:18]);
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid[9] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %b expected 0", out_valid[9]);
    end
    out_ready = '0;
  endtask

  task automatic test_async_reset();
    send(20, 2'b11);
    step();
    send(31, 2'b00);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid[20] !== 1'b1 || drop_count !== 8'h01) begin
      n_fail++;
      $display("FAIL pre_reset_state: got v20=%b cnt=%h expected v20=1 cnt=01", out_valid[20], drop_count);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 31'h0 || out_data !== 62'h0) begin
      n_fail++;
      $display("FAIL async_reset_lanes: got v=%h d=%h expected 0", out_valid, out_data);
    end
    n_checks++;
    if (drop_count !== 8'h00 || err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_err: got err=%b cnt=%h expected err=0 cnt=00", err_sticky, drop_count);
    end
    $display("txn async_reset: out_valid=%h drop_count=%h", out_valid, drop_count);
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_backpressure();
    test_fill_all();
    test_drops();
    test_concurrent();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
